// File: rtl/msrv32_dmem_if.sv
`timescale 1ns/1ps
// msrv32_dmem_if
// -----------------------------------------------------------------------------
// Bridges the core's single-request data-memory port onto an AHB-Lite master.
// One transfer is in flight at a time. Misaligned requests are rejected
// locally with an error completion. Loads return the raw bus word. The load
// unit uses ms_addr_lsb_out to pick out the byte or halfword lane.
//
// Optional feature: define DMEM_TIMEOUT_EN to bound the data phase. The
// transfer then ends with an error after TIMEOUT_CYCLES consecutive
// HREADY-low cycles. Without the macro the data phase waits indefinitely.
// -----------------------------------------------------------------------------
module msrv32_dmem_if #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    // core side
    input  logic        ms_req_in,
    input  logic        ms_we_in,
    input  logic [31:0] ms_addr_in,
    input  logic [1:0]  ms_size_in,
    input  logic [31:0] ms_wdata_in,
    output logic        ms_busy_out,
    output logic        ms_done_out,
    output logic [31:0] ms_rdata_out,
    output logic [1:0]  ms_addr_lsb_out,
    output logic        ms_resp_out,
    // AHB-Lite master side
    output logic [31:0] haddr_out,
    output logic [1:0]  htrans_out,
    output logic        hwrite_out,
    output logic [2:0]  hsize_out,
    output logic [31:0] hwdata_out,
    input  logic [31:0] hrdata_in,
    input  logic        hready_in,
    input  logic        hresp_in
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ADDR = 2'b01,
        S_DATA = 2'b10,
        S_ERR  = 2'b11
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // A zero timeout would leave the data phase with no legal length.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("msrv32_dmem_if: TIMEOUT_CYCLES must be at least 1");
    end

    // Size encodings and alignment: halves need addr[0]=0, words addr[1:0]=0.
    // Size 11 is not a legal core request and is always rejected.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] lsb);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lsb[0];
            2'b10:   bad = (lsb != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // The slave picks its lane from HADDR. Replicating the right-justified
    // store data across every lane means no shifter keyed on the address.
    function automatic logic [31:0] lane_replicate(input logic [1:0]  size,
                                                   input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            2'b00:   lanes = {4{data[7:0]}};
            2'b01:   lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

    state_e      state_q,  state_d;
    logic [31:0] addr_q,   addr_d;
    logic [1:0]  size_q,   size_d;
    logic        we_q,     we_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        done_q,   done_d;
    logic        resp_q,   resp_d;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // The phase ends on the low cycle that would bring the count to TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // Next-state and next-register logic for the transfer FSM.
    always_comb begin
        // NOTE: every _d starts from its hold value (pulses from 0), so no
        // branch below can leave a signal unassigned and infer a latch.
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        we_d     = we_q;
        hwdata_d = hwdata_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        resp_d   = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (ms_req_in) begin
                    addr_d   = ms_addr_in;
                    size_d   = ms_size_in;
                    we_d     = ms_we_in;
                    hwdata_d = lane_replicate(ms_size_in, ms_wdata_in);
                    if (is_misaligned(ms_size_in, ms_addr_in[1:0])) begin
                        // Rejected without touching the bus; completes next cycle.
                        done_d = 1'b1;
                        resp_d = 1'b1;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end

            S_ADDR: begin
                // Address and control stay registered until the slave takes them.
                if (hready_in) begin
                    state_d = S_DATA;
`ifdef DMEM_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end

            S_DATA: begin
                if (hresp_in) begin
                    if (hready_in) begin
                        // Slave collapsed the two-cycle error; finish it here.
                        done_d  = 1'b1;
                        resp_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (hready_in) begin
                    if (!we_q) begin
                        rdata_d = hrdata_in;
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
`ifdef DMEM_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    done_d  = 1'b1;
                    resp_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end

            S_ERR: begin
                // Second cycle of the AHB error response.
                if (hready_in) begin
                    done_d  = 1'b1;
                    resp_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        // NOTE: the datapath registers are reset along with the state. They
        // drive outputs directly, and those outputs must read 0 after reset.
        if (!rst_in) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            we_q     <= 1'b0;
            hwdata_q <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            resp_q   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // values from before the edge, whatever the statement order.
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            we_q     <= we_d;
            hwdata_q <= hwdata_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            resp_q   <= resp_d;
`ifdef DMEM_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
`endif
        end
    end

    // Core-side outputs. The response flag only ever rises together with done.
    assign ms_busy_out     = (state_q != S_IDLE);
    assign ms_done_out     = done_q;
    assign ms_resp_out     = resp_q;
    assign ms_rdata_out    = rdata_q;
    assign ms_addr_lsb_out = addr_q[1:0];

    // Bus outputs. NONSEQ is driven only in the address phase.
    assign htrans_out = (state_q == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr_out  = addr_q;
    assign hsize_out  = {1'b0, size_q};
    assign hwrite_out = we_q;
    assign hwdata_out = hwdata_q;

endmodule

// File: tb/tb_msrv32_dmem_if.sv
`timescale 1ns/1ps
// tb_msrv32_dmem_if
// Directed and randomized bench for the AHB-Lite data-memory bridge. The
// bench plays both the core and the bus slave. Expected values come from
// transfer-level rules: alignment, lane replication by multiplication, and the
// last load value. The bench has no model of the FSM itself.
// Timeout checks compile in when DMEM_TIMEOUT_EN is defined, which assumes the
// default TIMEOUT_CYCLES of 16.
module tb_msrv32_dmem_if;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        ms_req_in;
    logic        ms_we_in;
    logic [31:0] ms_addr_in;
    logic [1:0]  ms_size_in;
    logic [31:0] ms_wdata_in;
    logic        ms_busy_out;
    logic        ms_done_out;
    logic [31:0] ms_rdata_out;
    logic [1:0]  ms_addr_lsb_out;
    logic        ms_resp_out;
    logic [31:0] haddr_out;
    logic [1:0]  htrans_out;
    logic        hwrite_out;
    logic [2:0]  hsize_out;
    logic [31:0] hwdata_out;
    logic [31:0] hrdata_in;
    logic        hready_in;
    logic        hresp_in;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_rdata;

    msrv32_dmem_if dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .ms_req_in       (ms_req_in),
        .ms_we_in        (ms_we_in),
        .ms_addr_in      (ms_addr_in),
        .ms_size_in      (ms_size_in),
        .ms_wdata_in     (ms_wdata_in),
        .ms_busy_out     (ms_busy_out),
        .ms_done_out     (ms_done_out),
        .ms_rdata_out    (ms_rdata_out),
        .ms_addr_lsb_out (ms_addr_lsb_out),
        .ms_resp_out     (ms_resp_out),
        .haddr_out       (haddr_out),
        .htrans_out      (htrans_out),
        .hwrite_out      (hwrite_out),
        .hsize_out       (hsize_out),
        .hwdata_out      (hwdata_out),
        .hrdata_in       (hrdata_in),
        .hready_in       (hready_in),
        .hresp_in        (hresp_in)
    );

    always #5 clk_in = ~clk_in;

    // Watchdog: every step is cycle-scripted, so this only fires on a broken run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic bit misaligned(input logic [1:0] size, input logic [31:0] addr);
        int align;
        align = (size == 2'd3) ? 0 : (1 << size);
        return (align == 0) || ((addr % align) != 0);
    endfunction

    // Each byte lane carries the same data: repeat the low bits via multiplication.
    function automatic logic [31:0] lanes(input logic [1:0] size, input logic [31:0] data);
        if (size == 2'd0) return (data & 32'hFF)   * 32'h0101_0101;
        if (size == 2'd1) return (data & 32'hFFFF) * 32'h0001_0001;
        return data;
    endfunction

    // While busy the core side shows junk, which the bridge must ignore.
    task automatic noise();
        ms_req_in   = 1'($urandom_range(0, 1));
        ms_we_in    = 1'($urandom_range(0, 1));
        ms_addr_in  = $urandom;
        ms_size_in  = 2'($urandom_range(0, 3));
        ms_wdata_in = $urandom;
    endtask

    task automatic check_idle_quiet(input string tag);
        check({tag, ".busy"},   32'(ms_busy_out), 32'd0);
        check({tag, ".done"},   32'(ms_done_out), 32'd0);
        check({tag, ".resp"},   32'(ms_resp_out), 32'd0);
        check({tag, ".htrans"}, 32'(htrans_out),  32'd0);
    endtask

    // Called at a negedge. Issues an aligned request and walks through the
    // address phase. Returns at the first negedge of the data phase.
    task automatic begin_txn(input string tag, input logic we, input logic [31:0] addr,
                             input logic [1:0] size, input logic [31:0] wdata,
                             input int addr_waits);
        ms_req_in = 1'b1; ms_we_in = we; ms_addr_in = addr;
        ms_size_in = size; ms_wdata_in = wdata;
        hready_in = 1'b1; hresp_in = 1'b0;
        @(negedge clk_in);
        check({tag, ".a.busy"},   32'(ms_busy_out),     32'd1);
        check({tag, ".a.htrans"}, 32'(htrans_out),      32'd2);
        check({tag, ".a.haddr"},  haddr_out,            addr);
        check({tag, ".a.hsize"},  32'(hsize_out),       32'(size));
        check({tag, ".a.hwrite"}, 32'(hwrite_out),      32'(we));
        check({tag, ".a.lsb"},    32'(ms_addr_lsb_out), addr & 32'd3);
        check({tag, ".a.done"},   32'(ms_done_out),     32'd0);
        noise();
        for (int i = 0; i < addr_waits; i++) begin
            hready_in = 1'b0;
            @(negedge clk_in);
            check({tag, ".aw.htrans"}, 32'(htrans_out), 32'd2);
            check({tag, ".aw.haddr"},  haddr_out,       addr);
            noise();
        end
        hready_in = 1'b1;
        @(negedge clk_in);
        check({tag, ".d.htrans"}, 32'(htrans_out),  32'd0);
        check({tag, ".d.busy"},   32'(ms_busy_out), 32'd1);
        check({tag, ".d.done"},   32'(ms_done_out), 32'd0);
        if (we) check({tag, ".d.hwdata"}, hwdata_out, lanes(size, wdata));
        noise();
    endtask

    // Whole transfer, started at a negedge. Returns at the completion negedge
    // with the request dropped, so the caller can issue the next one back-to-back.
    task automatic run_txn(input string tag, input logic we, input logic [31:0] addr,
                           input logic [1:0] size, input logic [31:0] wdata,
                           input int addr_waits, input int data_waits,
                           input bit err, input logic [31:0] rd);
        if (misaligned(size, addr)) begin
            ms_req_in = 1'b1; ms_we_in = we; ms_addr_in = addr;
            ms_size_in = size; ms_wdata_in = wdata;
            hready_in = 1'b1; hresp_in = 1'b0;
            @(negedge clk_in);
            check({tag, ".mis.done"},   32'(ms_done_out),     32'd1);
            check({tag, ".mis.resp"},   32'(ms_resp_out),     32'd1);
            check({tag, ".mis.busy"},   32'(ms_busy_out),     32'd0);
            check({tag, ".mis.htrans"}, 32'(htrans_out),      32'd0);
            check({tag, ".mis.lsb"},    32'(ms_addr_lsb_out), addr & 32'd3);
            check({tag, ".mis.rdata"},  ms_rdata_out,         exp_rdata);
            ms_req_in = 1'b0;
            return;
        end
        begin_txn(tag, we, addr, size, wdata, addr_waits);
        if (err) begin
            hready_in = 1'b0; hresp_in = 1'b1;
            @(negedge clk_in);
            check({tag, ".e1.busy"}, 32'(ms_busy_out), 32'd1);
            check({tag, ".e1.done"}, 32'(ms_done_out), 32'd0);
            noise();
            hready_in = 1'b1; hresp_in = 1'b1;
            @(negedge clk_in);
            check({tag, ".e2.done"},  32'(ms_done_out), 32'd1);
            check({tag, ".e2.resp"},  32'(ms_resp_out), 32'd1);
            check({tag, ".e2.busy"},  32'(ms_busy_out), 32'd0);
            check({tag, ".e2.rdata"}, ms_rdata_out,     exp_rdata);
            hresp_in = 1'b0;
            ms_req_in = 1'b0;
            return;
        end
        for (int i = 0; i < data_waits; i++) begin
            hready_in = 1'b0;
            hrdata_in = $urandom;
            @(negedge clk_in);
            check({tag, ".dw.done"}, 32'(ms_done_out), 32'd0);
            check({tag, ".dw.busy"}, 32'(ms_busy_out), 32'd1);
            if (we) check({tag, ".dw.hwdata"}, hwdata_out, lanes(size, wdata));
            noise();
        end
        hready_in = 1'b1;
        hrdata_in = rd;
        @(negedge clk_in);
        if (!we) exp_rdata = rd;
        check({tag, ".c.done"},   32'(ms_done_out), 32'd1);
        check({tag, ".c.resp"},   32'(ms_resp_out), 32'd0);
        check({tag, ".c.busy"},   32'(ms_busy_out), 32'd0);
        check({tag, ".c.htrans"}, 32'(htrans_out),  32'd0);
        check({tag, ".c.rdata"},  ms_rdata_out,     exp_rdata);
        ms_req_in = 1'b0;
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] ad;

        rst_in = 1'b0; ms_req_in = 1'b0; ms_we_in = 1'b0; ms_addr_in = '0;
        ms_size_in = '0; ms_wdata_in = '0; hrdata_in = '0;
        hready_in = 1'b1; hresp_in = 1'b0;
        exp_rdata = '0;

        // Reset state
        @(negedge clk_in);
        @(negedge clk_in);
        check_idle_quiet("rst");
        check("rst.rdata",  ms_rdata_out,           32'd0);
        check("rst.haddr",  haddr_out,              32'd0);
        check("rst.hwdata", hwdata_out,             32'd0);
        check("rst.hsize",  32'(hsize_out),         32'd0);
        check("rst.hwrite", 32'(hwrite_out),        32'd0);
        check("rst.lsb",    32'(ms_addr_lsb_out),   32'd0);
        rst_in = 1'b1;
        @(negedge clk_in);
        check_idle_quiet("post_rst");

        // Zero-wait word load
        run_txn("ldw", 1'b0, 32'h100, 2'd2, 32'h0, 0, 0, 1'b0, 32'hAABB_CCDD);
        check("ldw.rdata", ms_rdata_out, 32'hAABB_CCDD);
        @(negedge clk_in);
        check_idle_quiet("ldw.after");

        // Byte store with two wait states
        run_txn("stb", 1'b1, 32'h103, 2'd0, 32'h0000_005A, 0, 2, 1'b0, 32'h1234_5678);
        check("stb.rdata_kept", ms_rdata_out, 32'hAABB_CCDD);

        // Misaligned half load, issued back-to-back in the completion cycle
        run_txn("ldh_mis", 1'b0, 32'h101, 2'd1, 32'h0, 0, 0, 1'b0, 32'h0);
        @(negedge clk_in);
        check_idle_quiet("ldh_mis.after");

        // Two-cycle error response
        run_txn("err", 1'b0, 32'h200, 2'd2, 32'h0, 1, 0, 1'b1, 32'h0);
        check("err.rdata_kept", ms_rdata_out, 32'hAABB_CCDD);

        // Halfword store with address-phase wait
        run_txn("sth", 1'b1, 32'h2002, 2'd1, 32'hDEAD_BEEF, 1, 1, 1'b0, 32'h0);

`ifdef DMEM_TIMEOUT_EN
        // Data phase stuck low: ends with an error on the 16th low cycle
        begin_txn("tmo", 1'b0, 32'h300, 2'd2, 32'h0, 0);
        hready_in = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk_in);
            if (k < 16) begin
                check("tmo.wait.done", 32'(ms_done_out), 32'd0);
                check("tmo.wait.busy", 32'(ms_busy_out), 32'd1);
            end else begin
                check("tmo.done",  32'(ms_done_out), 32'd1);
                check("tmo.resp",  32'(ms_resp_out), 32'd1);
                check("tmo.busy",  32'(ms_busy_out), 32'd0);
                check("tmo.rdata", ms_rdata_out,     exp_rdata);
            end
            noise();
        end
        ms_req_in = 1'b0;
        hready_in = 1'b1;
        @(negedge clk_in);
        check_idle_quiet("tmo.after");
`else
        // No timeout: a long stall keeps waiting, then completes normally
        run_txn("long", 1'b0, 32'h304, 2'd2, 32'h0, 0, 20, 1'b0, 32'h0BAD_F00D);
`endif

        // Reset in the middle of a stalled data phase
        begin_txn("rstmid", 1'b1, 32'h400, 2'd2, 32'hCAFE_F00D, 0);
        hready_in = 1'b0;
        @(negedge clk_in);
        check("rstmid.busy", 32'(ms_busy_out), 32'd1);
        rst_in = 1'b0;
        ms_req_in = 1'b0;
        @(negedge clk_in);
        exp_rdata = '0;
        check_idle_quiet("rstmid");
        check("rstmid.rdata",  ms_rdata_out,         32'd0);
        check("rstmid.haddr",  haddr_out,            32'd0);
        check("rstmid.hwdata", hwdata_out,           32'd0);
        check("rstmid.hsize",  32'(hsize_out),       32'd0);
        check("rstmid.hwrite", 32'(hwrite_out),      32'd0);
        check("rstmid.lsb",    32'(ms_addr_lsb_out), 32'd0);
        rst_in = 1'b1;
        hready_in = 1'b1;
        @(negedge clk_in);
        check_idle_quiet("rstmid.after");

        // Randomized transfers, mostly aligned, with random stalls and errors
        for (int n = 0; n < 60; n++) begin
            sz = 2'($urandom_range(0, 3));
            ad = $urandom;
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) ad = ad - (ad % (32'd1 << sz));
            run_txn("rnd", 1'($urandom_range(0, 1)), ad, sz, $urandom,
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0), $urandom);
            if ($urandom_range(0, 1) != 0) begin
                @(negedge clk_in);
                check_idle_quiet("rnd.gap");
                check("rnd.gap.rdata", ms_rdata_out, exp_rdata);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
